data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory responder for the RV32IM pipeline's MEM stage. It accepts READ/WRITE requests from the control unit together with the load/store type codes, holds BUSYWAIT high for a fixed access latency, performs byte/half/word stores with byte masking, and returns sign- or zero-extended load data. It is the memory-side end of the READ/WRITE/BUSYWAIT handshake.

## Interface
Parameters:
- ADDR_WIDTH, 10: byte-address bits used; the array holds 2^ADDR_WIDTH bytes. ADDRESS bits above this are ignored.
- LATENCY, 4: clock edges from request capture to access completion; must be at least 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  load request.
- WRITE  input  1  store request.
- ADDRESS  input  32  byte address (ALU result).
- WRITEDATA  input  32  store data (rs2).
- LOADSIGNAL  input  3  load type: 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU; 0, 6 and 7 return the full word.
- STORESIGNAL  input  2  store type: 1 SB, 2 SH, 3 SW; 0 writes no bytes.
- READDATA  output  32  extended load result, registered.
- BUSYWAIT  output  1  high while a request is outstanding.
- MISALIGNED  output  1  misaligned-access flag; present only with DMEM_MISALIGN_TRAP_EN.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If READ or WRITE is high at an edge, capture ADDRESS, WRITEDATA, LOADSIGNAL, STORESIGNAL and the request type. Load cnt = LATENCY-1, then go to WAIT.
  - If READ and WRITE are both high, WRITE wins and no read is performed.
- WAIT:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the access with the captured values and go to DONE.
- DONE:
  - Lasts one cycle, then go to IDLE.
  - Requests are ignored in DONE; the requester drops READ/WRITE in this cycle.
- BUSYWAIT is combinational: (state==IDLE && (READ||WRITE)) || state==WAIT.
- Store:
  - SB writes byte addr.
  - SH writes bytes {addr[..:1],0} and +1.
  - SW writes the four bytes of the word at addr[..:2].
  - Storage is little-endian; no other bytes change.
- Load:
  - Select the byte or half by the low address bits, then sign-extend (LB, LH) or zero-extend (LBU, LHU).
  - LW returns the aligned word.
  - The result is registered into READDATA at the completion edge.
  - READDATA holds its value until the next load completes; stores do not change it.
- Without DMEM_MISALIGN_TRAP_EN, misaligned accesses are aligned down: the half uses addr[0]=0 and the word uses addr[1:0]=0.
- Reset:
  - State goes to IDLE, cnt=0, READDATA=0, MISALIGNED=0.
  - BUSYWAIT=0 unless READ/WRITE is high.
  - Memory contents are not reset.
  - A reset in WAIT or DONE abandons the access with no memory write.

## Timing
- Request first visible in cycle T:
  - BUSYWAIT rises in cycle T (combinational).
  - Capture happens at edge T.
  - The access and the READDATA update happen at edge T+LATENCY.
  - BUSYWAIT falls after edge T+LATENCY.
  - DONE is the cycle after edge T+LATENCY.
  - The block returns to IDLE at edge T+LATENCY+1.
- BUSYWAIT is high for LATENCY+1 cycles per access.
- The earliest next capture is edge T+LATENCY+2.
- Changes on the inputs after edge T do not affect the access in flight.
- LATENCY=1: capture at T, complete at T+1.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - The MISALIGNED port exists.
  - An access is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]!=0.
  - On a misaligned store, no bytes are written.
  - On a misaligned load, READDATA is left unchanged.
  - MISALIGNED is set at the completion edge and cleared at the next capture or at reset.
  - Handshake timing is unchanged.
- DMEM_MISALIGN_TRAP_EN undefined: there is no MISALIGNED port, and addresses are aligned down.

## Structure
- Shared package:
  - LOADSIGNAL codes (LD_LB..LD_LHU, LD_NONE).
  - STORESIGNAL codes (ST_SB, ST_SH, ST_SW).
  - FSM state enum.
- These codes are shared with control_unit.
- One sub-module, load_align: a combinational block that takes the word, addr[1:0] and LOADSIGNAL and produces the extended 32-bit result.

## Test plan
- Reset with READ=0 → BUSYWAIT=0, READDATA=0.
- SW 0xDEADBEEF to 0x10, then LW 0x10 with LATENCY=4 → BUSYWAIT high for 5 cycles and READDATA=0xDEADBEEF at edge T+4.
- SB 0x80 to 0x21 over the word 0x11223344 at 0x20, then LB 0x21 → 0xFFFFFF80; LBU 0x21 → 0x00000080; LW 0x20 → 0x11228044.
- SH 0x8001 to 0x32, then LH 0x32 → 0xFFFF8001; LHU 0x32 → 0x00008001; LHU 0x30 → the original lower half.
- READ and WRITE both high with SW 0x5 to 0x40 → the word at 0x40 reads 5, READDATA is unchanged. Assert RESET at edge T+2 of a SW → the word is not written and BUSYWAIT drops.
- With DMEM_MISALIGN_TRAP_EN: SW to 0x41 → MISALIGNED=1 and no word changes. Without the macro: SW to 0x41 writes the word at 0x40.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared codes for the MEM-stage data memory: load/store type encodings
// (common with control_unit), FSM state encodings and store-lane helpers.
package data_mem_ctrl_pkg;

    // LOADSIGNAL codes; anything not listed returns the full word
    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LH   = 3'd2;
    localparam logic [2:0] LD_LW   = 3'd3;
    localparam logic [2:0] LD_LBU  = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;

    // STORESIGNAL codes
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_SB   = 2'd1;
    localparam logic [1:0] ST_SH   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    // Legacy state encodings, kept bit-identical for drop-in compatibility
    localparam logic [1:0] S_IDLE_ENC = 2'd0;
    localparam logic [1:0] S_WAIT_ENC = 2'd1;
    localparam logic [1:0] S_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = S_IDLE_ENC,
        S_WAIT = S_WAIT_ENC,
        S_DONE = S_DONE_ENC
    } state_e;

    // Byte-lane enables within the addressed word; halves and words align down
    function automatic logic [3:0] store_byte_en(input logic [1:0] st, input logic [1:0] a);
        logic [3:0] be;
        case (st)
            ST_SB:   be = 4'b0001 << a;
            ST_SH:   be = a[1] ? 4'b1100 : 4'b0011;
            ST_SW:   be = 4'b1111;
            ST_NONE: be = 4'b0000;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across lanes so each enabled lane sees its byte
    function automatic logic [31:0] store_lanes(input logic [1:0] st, input logic [31:0] wd);
        logic [31:0] d;
        case (st)
            ST_SB:   d = {4{wd[7:0]}};
            ST_SH:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Half with addr[0]=1 or word with addr[1:0]!=0
    function automatic logic access_misaligned(input logic is_wr, input logic [2:0] ld,
                                               input logic [1:0] st, input logic [1:0] a);
        logic half, word;
        if (is_wr) begin
            half = (st == ST_SH);
            word = (st == ST_SW);
        end else begin
            half = (ld == LD_LH) || (ld == LD_LHU);
            word = !(half || (ld == LD_LB) || (ld == LD_LBU));
        end
        return (half && a[0]) || (word && (a != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_ctrl_load_align.sv
// Load alignment: selects the byte/half of a memory word by the low address
// bits and sign- or zero-extends it according to LOADSIGNAL.
module data_mem_ctrl_load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  load_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection and extension
    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
        case (load_i)
            LD_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data_o = {24'h0, byte_sel};
            LD_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  data_o = {16'h0, half_sel};
            LD_LW:   data_o = word_i;
            LD_NONE: data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MEM stage: READ/WRITE/BUSYWAIT handshake with
// a fixed access latency, byte-masked stores and extended loads.
// Optional DMEM_MISALIGN_TRAP_EN: flags misaligned accesses on MISALIGNED and
// suppresses them instead of aligning the address down.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITEDATA,
    input  logic [2:0]  LOADSIGNAL,
    input  logic [1:0]  STORESIGNAL,
    output logic [31:0] READDATA,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        MISALIGNED,
`endif
    output logic        BUSYWAIT
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            ls_q, ls_d;
    logic [1:0]            ss_q, ss_d;
    logic [31:0]           readdata_q, readdata_d;
    logic [7:0]            mem_q [2**ADDR_WIDTH];

    logic                  complete;
    logic                  trap;
    logic                  mem_we;
    logic [3:0]            byte_en;
    logic [31:0]           lane_data;
    logic [ADDR_WIDTH-3:0] word_base;
    logic [31:0]           rd_word;
    logic [31:0]           load_data;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH];

    assign word_base = addr_q[ADDR_WIDTH-1:2];
    assign rd_word   = {mem_q[{word_base, 2'd3}], mem_q[{word_base, 2'd2}],
                        mem_q[{word_base, 2'd1}], mem_q[{word_base, 2'd0}]};

    data_mem_ctrl_load_align u_load_align (
        .word_i (rd_word),
        .addr_i (addr_q[1:0]),
        .load_i (ls_q),
        .data_o (load_data)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;
    assign trap       = access_misaligned(is_write_q, ls_q, ss_q, addr_q[1:0]);
    assign MISALIGNED = misaligned_q;
`else
    assign trap = 1'b0;
`endif

    // Handshake FSM: capture in IDLE, count down in WAIT, one DONE cycle
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ls_d       = ls_q;
        ss_d       = ss_q;
        readdata_d = readdata_q;
        complete   = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (READ || WRITE) begin
                    is_write_d = WRITE;
                    addr_d     = ADDRESS[ADDR_WIDTH-1:0];
                    wdata_d    = WRITEDATA;
                    ls_d       = LOADSIGNAL;
                    ss_d       = STORESIGNAL;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = S_WAIT;
`ifdef DMEM_MISALIGN_TRAP_EN
                    misaligned_d = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = S_DONE;
                    if (!is_write_q && !trap) begin
                        readdata_d = load_data;
                    end
`ifdef DMEM_MISALIGN_TRAP_EN
                    misaligned_d = trap;
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Store enables; a reset at the completion edge abandons the write
    always_comb begin
        byte_en   = store_byte_en(ss_q, addr_q[1:0]);
        lane_data = store_lanes(ss_q, wdata_q);
        mem_we    = complete && is_write_q && !trap && !RESET;
    end

    // Control and result registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ls_q       <= '0;
            ss_q       <= '0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ls_q       <= ls_d;
            ss_q       <= ss_d;
            readdata_q <= readdata_d;
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // Misalignment flag register
    always_ff @(posedge CLK) begin
        if (RESET) misaligned_q <= 1'b0;
        else       misaligned_q <= misaligned_d;
    end
`endif

    // Byte-addressed storage, not reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) mem_q[{word_base, i[1:0]}] <= lane_data[8*i +: 8];
            end
        end
    end

    assign READDATA = readdata_q;
    assign BUSYWAIT = ((state_q == S_IDLE) && (READ || WRITE)) || (state_q == S_WAIT);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (LATENCY=4).
module tb_data_mem_ctrl;

    localparam logic [2:0] LB = 3'd1, LH = 3'd2, LW = 3'd3, LBU = 3'd4, LHU = 3'd5;
    localparam logic [1:0] SN = 2'd0, SB = 2'd1, SH = 2'd2, SW = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writedata = '0;
    logic [2:0]  loadsignal = '0;
    logic [1:0]  storesignal = '0;
    logic [31:0] readdata;
    logic        busywait;
`ifdef DMEM_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(4)) dut (
        .CLK         (clk),
        .RESET       (reset),
        .READ        (read),
        .WRITE       (write),
        .ADDRESS     (address),
        .WRITEDATA   (writedata),
        .LOADSIGNAL  (loadsignal),
        .STORESIGNAL (storesignal),
        .READDATA    (readdata),
`ifdef DMEM_MISALIGN_TRAP_EN
        .MISALIGNED  (misaligned),
`endif
        .BUSYWAIT    (busywait)
    );

    // One full handshake; inputs other than READ/WRITE are scrambled after
    // capture. busy counts sampled cycles with BUSYWAIT high, pre_rd is
    // READDATA just before the completion edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] ls, input logic [1:0] ss,
                          output int busy, output logic [31:0] pre_rd);
        @(negedge clk);
        read = rd; write = wr; address = a; writedata = wd;
        loadsignal = ls; storesignal = ss;
        #1;
        busy = busywait ? 1 : 0;
        pre_rd = readdata;
        @(posedge clk); #1;
        address = ~a; writedata = ~wd; loadsignal = ls ^ 3'd7; storesignal = ss ^ 2'd3;
        if (busywait) busy++;
        for (int k = 0; k < 20 && busywait; k++) begin
            pre_rd = readdata;
            @(posedge clk); #1;
            if (busywait) busy++;
        end
        read = 1'b0; write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busywait !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busywait); end
        checks++;
        if (readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata: got %h expected 00000000", readdata); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk); read = 1'b1; #1;
        checks++;
        if (busywait !== 1'b1) begin failures++; $display("FAIL idle_busy_comb: got %b expected 1", busywait); end
        read = 1'b0; #1;
        checks++;
        if (busywait !== 1'b0) begin failures++; $display("FAIL idle_busy_drop: got %b expected 0", busywait); end
    endtask

    task automatic test_sw_lw();
        int busy; logic [31:0] pre;
        access(0, 1, 32'h10, 32'hDEADBEEF, LW, SW, busy, pre);
        checks++;
        if (busy !== 5) begin failures++; $display("FAIL sw_busy_cycles: got %0d expected 5", busy); end
        checks++;
        if (readdata !== 32'h0) begin failures++; $display("FAIL sw_keeps_readdata: got %h expected 00000000", readdata); end
        access(1, 0, 32'h10, 32'h0, LW, SN, busy, pre);
        checks++;
        if (busy !== 5) begin failures++; $display("FAIL lw_busy_cycles: got %0d expected 5", busy); end
        checks++;
        if (pre !== 32'h0) begin failures++; $display("FAIL lw_early_update: got %h expected 00000000", pre); end
        checks++;
        if (readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_10: got %h expected deadbeef", readdata); end
    endtask

    task automatic test_byte();
        int busy; logic [31:0] pre;
        access(0, 1, 32'h20, 32'h11223344, LW, SW, busy, pre);
        access(0, 1, 32'h21, 32'hAAAAAA80, LW, SB, busy, pre);
        checks++;
        if (readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sb_keeps_readdata: got %h expected deadbeef", readdata); end
        access(1, 0, 32'h21, 32'h0, LB, SN, busy, pre);
        checks++;
        if (readdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_21: got %h expected ffffff80", readdata); end
        access(1, 0, 32'h21, 32'h0, LBU, SN, busy, pre);
        checks++;
        if (readdata !== 32'h00000080) begin failures++; $display("FAIL lbu_21: got %h expected 00000080", readdata); end
        access(1, 0, 32'h20, 32'h0, LW, SN, busy, pre);
        checks++;
        if (readdata !== 32'h11228044) begin failures++; $display("FAIL lw_20: got %h expected 11228044", readdata); end
        access(1, 0, 32'h20, 32'h0, LB, SN, busy, pre);
        checks++;
        if (readdata !== 32'h00000044) begin failures++; $display("FAIL lb_20: got %h expected 00000044", readdata); end
        access(1, 0, 32'h10, 32'h0, 3'd7, SN, busy, pre);
        checks++;
        if (readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ld7_10: got %h expected deadbeef", readdata); end
    endtask

    task automatic test_half();
        int busy; logic [31:0] pre;
        access(0, 1, 32'h30, 32'hCAFEBABE, LW, SW, busy, pre);
        access(0, 1, 32'h32, 32'hFFFF8001, LW, SH, busy, pre);
        access(1, 0, 32'h32, 32'h0, LH, SN, busy, pre);
        checks++;
        if (readdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_32: got %h expected ffff8001", readdata); end
        access(1, 0, 32'h32, 32'h0, LHU, SN, busy, pre);
        checks++;
        if (readdata !== 32'h00008001) begin failures++; $display("FAIL lhu_32: got %h expected 00008001", readdata); end
        access(1, 0, 32'h30, 32'h0, LHU, SN, busy, pre);
        checks++;
        if (readdata !== 32'h0000BABE) begin failures++; $display("FAIL lhu_30: got %h expected 0000babe", readdata); end
        access(1, 0, 32'h30, 32'h0, LW, SN, busy, pre);
        checks++;
        if (readdata !== 32'h8001BABE) begin failures++; $display("FAIL lw_30: got %h expected 8001babe", readdata); end
        access(1, 0, 32'h33, 32'h0, LH, SN, busy, pre);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (readdata !== 32'h8001BABE) begin failures++; $display("FAIL lh_33_trap: got %h expected 8001babe", readdata); end
`else
        checks++;
        if (readdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_33_aligned: got %h expected ffff8001", readdata); end
`endif
    endtask

    task automatic test_rw_both();
        int busy; logic [31:0] pre;
        access(1, 0, 32'h10, 32'h0, LW, SN, busy, pre);
        access(1, 1, 32'h40, 32'h5, LW, SW, busy, pre);
        checks++;
        if (readdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_keeps_readdata: got %h expected deadbeef", readdata); end
        access(1, 0, 32'h40, 32'h0, LW, SN, busy, pre);
        checks++;
        if (readdata !== 32'h00000005) begin failures++; $display("FAIL rw_lw_40: got %h expected 00000005", readdata); end
        access(0, 1, 32'h40, 32'hFFFFFFFF, LW, SN, busy, pre);
        access(1, 0, 32'h40, 32'h0, LW, SN, busy, pre);
        checks++;
        if (readdata !== 32'h00000005) begin failures++; $display("FAIL st_none_40: got %h expected 00000005", readdata); end
    endtask

    task automatic test_reset_abort();
        int busy; logic [31:0] pre;
        access(0, 1, 32'h50, 32'hAAAA5555, LW, SW, busy, pre);
        @(negedge clk);
        write = 1'b1; address = 32'h50; writedata = 32'h12345678; storesignal = SW;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busywait !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busywait); end
        @(negedge clk); reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busywait !== 1'b0) begin failures++; $display("FAIL abort_idle: got %b expected 0", busywait); end
        checks++;
        if (readdata !== 32'h0) begin failures++; $display("FAIL abort_readdata_reset: got %h expected 00000000", readdata); end
        access(1, 0, 32'h50, 32'h0, LW, SN, busy, pre);
        checks++;
        if (readdata !== 32'hAAAA5555) begin failures++; $display("FAIL abort_no_write: got %h expected aaaa5555", readdata); end
    endtask

    task automatic test_misaligned();
        int busy; logic [31:0] pre;
        access(0, 1, 32'h41, 32'h0BADF00D, LW, SW, busy, pre);
        checks++;
        if (busy !== 5) begin failures++; $display("FAIL mis_busy_cycles: got %0d expected 5", busy); end
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_flag: got %b expected 1", misaligned); end
        access(1, 0, 32'h40, 32'h0, LW, SN, busy, pre);
        checks++;
        if (readdata !== 32'h00000005) begin failures++; $display("FAIL mis_no_write: got %h expected 00000005", readdata); end
        checks++;
        if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_flag_clear: got %b expected 0", misaligned); end
`else
        access(1, 0, 32'h40, 32'h0, LW, SN, busy, pre);
        checks++;
        if (readdata !== 32'h0BADF00D) begin failures++; $display("FAIL mis_aligned_down: got %h expected 0badf00d", readdata); end
`endif
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_byte();
        test_half();
        test_rw_both();
        test_reset_abort();
        test_misaligned();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
